execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 142 ++++++++++++++
 tb/tb_execute_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: two-stage elastic execute pipeline (B shifter + operand latch, then ALU result latch).
// Define EXECUTE_STATUS_EN to build the {Z,N,V} status register; otherwise status is tied to 3'b000.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [1:0]  shift,
  input  logic [1:0]  ALUop,
  input  logic [2:0]  writenum_in,
  input  logic        wb_en,
  input  logic        out_ready,
  output logic [15:0] C,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        out_valid,
  output logic [2:0]  status
);

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [2:0]  wn;
    logic        wb;
  } s1_t;

  s1_t         s1_q, s1_d;
  logic        s1_valid_q, s1_valid_d;
  logic [15:0] c_q, c_d;
  logic [2:0]  wn_q, wn_d;
  logic        wb_q, wb_d;
  logic        out_valid_q, out_valid_d;

  logic        s2_adv, in_fire, out_fire;
  logic [15:0] b_sh, alu_res;

  // S1 drains into S2 whenever S2 is empty or retiring this same edge.
  always_comb begin
    s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
    in_ready = ~s1_valid_q | s2_adv;
    in_fire  = in_valid & in_ready;
    out_fire = out_valid_q & out_ready;
  end

  always_comb begin
    case (shift)
      2'b01:   b_sh = {B[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, B[15:1]};
      2'b11:   b_sh = {B[15], B[15:1]};
      default: b_sh = B;
    endcase
  end

  always_comb begin
    case (s1_q.op)
      2'b00:   alu_res = s1_q.a + s1_q.b;
      2'b01:   alu_res = s1_q.a - s1_q.b;
      2'b10:   alu_res = s1_q.a & s1_q.b;
      default: alu_res = ~s1_q.b;
    endcase
  end

  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = (s1_valid_q & ~s2_adv) | in_fire;
    c_d         = c_q;
    wn_d        = wn_q;
    wb_d        = wb_q;
    out_valid_d = (out_valid_q & ~out_ready) | s2_adv;
    if (in_fire) begin
      s1_d.a  = A;
      s1_d.b  = b_sh;
      s1_d.op = ALUop;
      s1_d.wn = writenum_in;
      s1_d.wb = wb_en;
    end
    if (s2_adv) begin
      c_d  = alu_res;
      wn_d = s1_q.wn;
      wb_d = s1_q.wb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      c_q         <= 16'h0000;
      wn_q        <= 3'b000;
      wb_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      c_q         <= c_d;
      wn_q        <= wn_d;
      wb_q        <= wb_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign C         = c_q;
  assign writenum  = wn_q;
  assign out_valid = out_valid_q;
  assign write     = out_fire & wb_q;

`ifdef EXECUTE_STATUS_EN
  logic [2:0] flags_q, flags_d, status_q, status_d;
  logic       v_add, v_sub, alu_v;

  // Flags travel with the result in S2 and become visible only when it retires.
  always_comb begin
    v_add = (s1_q.a[15] == s1_q.b[15]) & (alu_res[15] != s1_q.a[15]);
    v_sub = (s1_q.a[15] != s1_q.b[15]) & (alu_res[15] != s1_q.a[15]);
    case (s1_q.op)
      2'b00:   alu_v = v_add;
      2'b01:   alu_v = v_sub;
      default: alu_v = 1'b0;
    endcase
    flags_d  = s2_adv   ? {(alu_res == 16'h0000), alu_res[15], alu_v} : flags_q;
    status_d = out_fire ? flags_q : status_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q  <= 3'b000;
      status_q <= 3'b000;
    end else begin
      flags_q  <= flags_d;
      status_q <= status_d;
    end
  end

  assign status = status_q;
`else
  assign status = 3'b000;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against an in-order queue model.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] A = '0, B = '0;
  logic [1:0]  shift = '0, ALUop = '0;
  logic [2:0]  writenum_in = '0;
  logic        wb_en = 1'b0, out_ready = 1'b1;
  logic [15:0] C;
  logic [2:0]  writenum;
  logic        write, out_valid;
  logic [2:0]  status;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .shift(shift), .ALUop(ALUop), .writenum_in(writenum_in),
    .wb_en(wb_en), .out_ready(out_ready), .C(C), .writenum(writenum),
    .write(write), .out_valid(out_valid), .status(status)
  );

  typedef struct {
    logic [15:0] c;
    logic [2:0]  wn;
    logic        wb;
    logic [2:0]  fl;
  } exp_t;

  // Reference: integer arithmetic on unsigned/signed interpretations of the operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] sh, input logic [1:0] op,
                                 input logic [2:0] wn, input logic w);
    int ua, ub, sa, sb, r, sr;
    logic v;
    exp_t e;
    ua = int'(a);
    ub = int'(b);
    case (sh)
      2'd1:    ub = (ub * 2) % 65536;
      2'd2:    ub = ub / 2;
      2'd3:    ub = ub / 2 + ((ub >= 32768) ? 32768 : 0);
      default: ub = ub;
    endcase
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    v  = 1'b0;
    case (op)
      2'd0: begin r = (ua + ub) % 65536; sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      2'd1: begin r = (ua - ub + 65536) % 65536; sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      2'd2: r = ua & ub;
      default: r = 65535 - ub;
    endcase
    e.c  = r[15:0];
    e.wn = wn;
    e.wb = w;
    e.fl = {(r == 0), (r >= 32768), v};
    return e;
  endfunction

  function automatic logic [2:0] st(input logic [2:0] fl);
`ifdef EXECUTE_STATUS_EN
    return fl;
`else
    return 3'b000 & fl;
`endif
  endfunction

  task automatic put(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sh,
                     input logic [1:0] op, input logic [2:0] wn, input logic w);
    A = a; B = b; shift = sh; ALUop = op; writenum_in = wn; wb_en = w; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1 reset = 1'b1;
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (write !== 1'b0) begin fails++; $display("FAIL reset_write got %b want 0", write); end
    tests++; if (C !== 16'h0000) begin fails++; $display("FAIL reset_C got %h want 0000", C); end
    tests++; if (writenum !== 3'b000) begin fails++; $display("FAIL reset_writenum got %b want 000", writenum); end
    tests++; if (status !== 3'b000) begin fails++; $display("FAIL reset_status got %b want 000", status); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    out_ready = 1'b1;
    put(16'h0003, 16'h0004, 2'b00, 2'b00, 3'd2, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_latency out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    tests++; if (C !== 16'h0007) begin fails++; $display("FAIL basic_C got %h want 0007", C); end
    tests++; if (writenum !== 3'd2) begin fails++; $display("FAIL basic_writenum got %0d want 2", writenum); end
    tests++; if (write !== 1'b1) begin fails++; $display("FAIL basic_write got %b want 1", write); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_retire out_valid got %b want 0", out_valid); end
    tests++; if (status !== 3'b000) begin fails++; $display("FAIL basic_status got %b want 000", status); end
  endtask

  task automatic test_flags();
    logic [15:0] ta[3], tb[3], tc[3];
    logic [1:0]  tsh[3], top[3];
    logic [2:0]  tst[3];
    ta[0] = 16'h7FFF; tb[0] = 16'h0001; tsh[0] = 2'b00; top[0] = 2'b00; tc[0] = 16'h8000; tst[0] = 3'b011;
    ta[1] = 16'h0005; tb[1] = 16'h0005; tsh[1] = 2'b00; top[1] = 2'b01; tc[1] = 16'h0000; tst[1] = 3'b100;
    ta[2] = 16'h0000; tb[2] = 16'h8002; tsh[2] = 2'b11; top[2] = 2'b11; tc[2] = 16'h3FFE; tst[2] = 3'b000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      put(ta[i], tb[i], tsh[i], top[i], 3'(i + 3), 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (C !== tc[i] || out_valid !== 1'b1) begin
        fails++; $display("FAIL flags_C[%0d] got %h/%b want %h/1", i, C, out_valid, tc[i]);
      end
      @(posedge clk); #1;
      tests++; if (status !== st(tst[i])) begin
        fails++; $display("FAIL flags_status[%0d] got %b want %b", i, status, st(tst[i]));
      end
    end
  endtask

  task automatic test_stall();
    exp_t        e[4];
    logic [15:0] ra[4], rb[4];
    logic [1:0]  rsh[4], rop[4];
    logic [15:0] held = '0;
    int ni = 0;
    int no = 0;
    for (int i = 0; i < 4; i++) begin
      ra[i] = 16'($urandom); rb[i] = 16'($urandom);
      rsh[i] = 2'($urandom); rop[i] = 2'($urandom);
      e[i] = model(ra[i], rb[i], rsh[i], rop[i], 3'(i + 1), 1'b1);
    end
    for (int cyc = 0; cyc < 40 && no < 4; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 4);
      if (ni < 4) put(ra[ni], rb[ni], rsh[ni], rop[ni], 3'(ni + 1), 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (cyc == 1) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_second_accept in_ready got %b want 1", in_ready); end
      end
      if (cyc == 2) begin
        tests++; if (in_ready !== 1'b0 || ni != 2) begin
          fails++; $display("FAIL stall_backpressure in_ready got %b accepts %0d want 0 after 2", in_ready, ni);
        end
        tests++; if (out_valid !== 1'b1 || C !== e[0].c) begin
          fails++; $display("FAIL stall_head got %h/%b want %h/1", C, out_valid, e[0].c);
        end
        held = C;
      end
      if (cyc == 3) begin
        tests++; if (C !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
          fails++; $display("FAIL stall_hold C got %h want %h (ov %b ir %b)", C, held, out_valid, in_ready);
        end
      end
      if (cyc == 4) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release in_ready got %b want 1", in_ready); end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        tests++; if (no >= 4 || C !== e[no].c || writenum !== e[no].wn) begin
          fails++; $display("FAIL stall_order[%0d] got %h/%0d want %h/%0d", no, C, writenum, e[no % 4].c, e[no % 4].wn);
        end
        no++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) ni++;
    end
    in_valid = 1'b0;
    tests++; if (no != 4) begin fails++; $display("FAIL stall_drain got %0d results want 4", no); end
  endtask

  task automatic test_wb_and_reset();
    exp_t e;
    logic [15:0] a, b;
    int seen = 0;
    a = 16'($urandom); b = 16'($urandom);
    e = model(a, b, 2'b00, 2'b10, 3'd5, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    put(a, b, 2'b00, 2'b10, 3'd5, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || write !== 1'b0 || C !== e.c) begin
      fails++; $display("FAIL nowb ov/write/C got %b/%b/%h want 1/0/%h", out_valid, write, C, e.c);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    put(16'h1111, 16'h2222, 2'b00, 2'b00, 3'd6, 1'b1);
    @(posedge clk); #1;
    put(16'h3333, 16'h4444, 2'b00, 2'b00, 3'd7, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL full_before_reset ov/ir got %b/%b want 1/0", out_valid, in_ready);
    end
    out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || write !== 1'b0 || C !== 16'h0000 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midreset ov/write/C/ir got %b/%b/%h/%b want 0/0/0000/1", out_valid, write, C, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL post_reset_emit got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t h;
    logic [2:0] exp_status = 3'b000;
    logic       stalled = 1'b0;
    int         drained;
    in_valid = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 400) begin
        put(16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      tests++; if (status !== exp_status) begin
        fails++; $display("FAIL rnd_status cyc %0d got %b want %b", cyc, status, exp_status);
      end
      if (stalled) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rnd_hold cyc %0d out_valid got %b want 1", cyc, out_valid); end
      end
      if (out_valid === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rnd_spurious cyc %0d C %h with no pending result", cyc, C);
        end else if (C !== q[0].c || writenum !== q[0].wn || write !== (out_ready & q[0].wb)) begin
          fails++; $display("FAIL rnd_result cyc %0d got C %h wn %0d wr %b want C %h wn %0d wr %b",
                            cyc, C, writenum, write, q[0].c, q[0].wn, out_ready & q[0].wb);
        end
        if (out_ready === 1'b1 && q.size() != 0) begin
          h = q.pop_front();
          exp_status = st(h.fl);
        end
      end
      stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
      if (in_valid === 1'b1 && in_ready === 1'b1)
        q.push_back(model(A, B, shift, ALUop, writenum_in, wb_en));
    end
    drained = q.size();
    tests++; if (drained != 0) begin fails++; $display("FAIL rnd_drain got %0d pending want 0", drained); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_stall();
    test_wb_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
